seg7_frame_monitor: RTL and testbench

Receive-side monitor for the seven-segment output bus. It samples an asynchronous 7-bit segment bus and filters out glitches. It decodes each accepted frame back to a hex digit and measures the number of clock cycles between frame changes. Bench and board-level checks use it to confirm that animation content and speed settings actually reach the pins.

---
 rtl/seg7_frame_monitor_pkg.sv | 69 ++++++
 rtl/seg7_frame_monitor_if.sv | 26 ++
 rtl/seg7_frame_monitor_filter.sv | 42 ++++
 rtl/seg7_frame_monitor.sv | 127 ++++++++++++
 tb/tb_seg7_frame_monitor.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/seg7_frame_monitor_pkg.sv
// Shared definitions for the seven-segment frame monitor: glyph table,
// segment bit positions, measurement states and the glyph decoder.
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  typedef enum logic [2:0] {
    SEG_BIT_A = 3'd0,
    SEG_BIT_B = 3'd1,
    SEG_BIT_C = 3'd2,
    SEG_BIT_D = 3'd3,
    SEG_BIT_E = 3'd4,
    SEG_BIT_F = 3'd5,
    SEG_BIT_G = 3'd6
  } seg_bit_t;

  typedef enum logic {
    IDLE,
    MEAS
  } meas_state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] nibble;
  } hex_t;

  // Patterns outside the glyph table decode as invalid with a zero nibble.
  function automatic hex_t seg7_to_hex(input logic [6:0] pattern);
    hex_t r;
    r.valid  = 1'b1;
    r.nibble = 4'h0;
    case (pattern)
      SEG_0:   r.nibble = 4'h0;
      SEG_1:   r.nibble = 4'h1;
      SEG_2:   r.nibble = 4'h2;
      SEG_3:   r.nibble = 4'h3;
      SEG_4:   r.nibble = 4'h4;
      SEG_5:   r.nibble = 4'h5;
      SEG_6:   r.nibble = 4'h6;
      SEG_7:   r.nibble = 4'h7;
      SEG_8:   r.nibble = 4'h8;
      SEG_9:   r.nibble = 4'h9;
      SEG_A:   r.nibble = 4'hA;
      SEG_B:   r.nibble = 4'hB;
      SEG_C:   r.nibble = 4'hC;
      SEG_D:   r.nibble = 4'hD;
      SEG_E:   r.nibble = 4'hE;
      SEG_F:   r.nibble = 4'hF;
      default: r.valid  = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_frame_monitor_if.sv
// Bundle of the monitored segment bus and everything the monitor reports.
interface seg7_frame_monitor_if #(
  parameter int PERIOD_WIDTH = 24
);
  logic [6:0]              segments_in;
  logic [6:0]              frame;
  logic                    frame_valid;
  logic [3:0]              digit;
  logic                    digit_valid;
  logic [PERIOD_WIDTH-1:0] period;
  logic                    period_valid;
  logic                    period_stable;
  logic                    locked;

  modport master (
    input  segments_in,
    output frame, frame_valid, digit, digit_valid,
    output period, period_valid, period_stable, locked
  );

  modport slave (
    output segments_in,
    input  frame, frame_valid, digit, digit_valid,
    input  period, period_valid, period_stable, locked
  );
endinterface

// File: rtl/seg7_frame_monitor_filter.sv
// Two-flop synchronizer plus stability counter; raises accept for one cycle
// when a new pattern has been steady long enough and differs from the frame.
module seg7_stable_filter #(
  parameter int STABLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] segments_in,
  input  logic [6:0] frame,
  output logic [6:0] candidate,
  output logic       accept
);

  localparam int              CW      = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [6:0]    sync1;
  logic [6:0]    seg_s;
  logic [CW-1:0] stable_cnt;

  // The counter saturates so a held pattern keeps qualifying without wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1      <= '0;
      seg_s      <= '0;
      candidate  <= '0;
      stable_cnt <= '0;
    end else begin
      sync1 <= segments_in;
      seg_s <= sync1;
      if (seg_s != candidate) begin
        candidate  <= seg_s;
        stable_cnt <= '0;
      end else if (stable_cnt != CNT_MAX) begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

  assign accept = (seg_s == candidate) && (stable_cnt == CNT_MAX) && (candidate != frame);

endmodule

// File: rtl/seg7_frame_monitor.sv
// Receive-side monitor: filters the segment bus, decodes accepted frames and
// measures the cycle distance between successive frame changes.
module seg7_frame_monitor
  import seg7_pkg::*;
#(
  parameter int                      STABLE_CYCLES = 16,
  parameter int                      PERIOD_WIDTH  = 24,
  parameter logic [PERIOD_WIDTH-1:0] TIMEOUT       = 'hFF_FFFF,
  parameter int                      TOLERANCE     = 1024
) (
  input logic                clk,
  input logic                reset,
  seg7_frame_monitor_if.master mon
);

  localparam logic [PERIOD_WIDTH-1:0] TOL_W = PERIOD_WIDTH'(TOLERANCE);

  logic [6:0] candidate;
  logic       accept;

  logic [6:0]              frame_q;
  logic                    frame_valid_q;
  logic [3:0]              digit_q;
  logic                    digit_valid_q;
  logic [PERIOD_WIDTH-1:0] period_q, period_n;
  logic                    period_valid_q, period_valid_n;
  logic                    period_stable_q, period_stable_n;
  logic                    locked_q, locked_n;
  logic [PERIOD_WIDTH-1:0] count, count_n;
  logic [PERIOD_WIDTH-1:0] count_inc;
  logic [PERIOD_WIDTH-1:0] period_diff;
  meas_state_t             state, state_n;
  hex_t                    dec;

  seg7_stable_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk        (clk),
    .reset      (reset),
    .segments_in(mon.segments_in),
    .frame      (frame_q),
    .candidate  (candidate),
    .accept     (accept)
  );

  assign dec = seg7_to_hex(candidate);

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
      digit_q       <= '0;
      digit_valid_q <= 1'b0;
    end else begin
      frame_valid_q <= accept;
      if (accept) begin
        frame_q       <= candidate;
        digit_q       <= dec.nibble;
        digit_valid_q <= dec.valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      count           <= '0;
      period_q        <= '0;
      period_valid_q  <= 1'b0;
      period_stable_q <= 1'b0;
      locked_q        <= 1'b0;
    end else begin
      state           <= state_n;
      count           <= count_n;
      period_q        <= period_n;
      period_valid_q  <= period_valid_n;
      period_stable_q <= period_stable_n;
      locked_q        <= locked_n;
    end
  end

  assign count_inc   = count + PERIOD_WIDTH'(1);
  assign period_diff = (count_inc >= period_q) ? (count_inc - period_q) : (period_q - count_inc);

  // An accept wins over a simultaneous timeout, so the period is never lost.
  always_comb begin
    state_n         = state;
    count_n         = count;
    period_n        = period_q;
    period_valid_n  = 1'b0;
    period_stable_n = period_stable_q;
    locked_n        = locked_q;
    case (state)
      IDLE: begin
        count_n = '0;
        if (accept) state_n = MEAS;
      end
      MEAS: begin
        if (accept) begin
          period_n        = count_inc;
          period_valid_n  = 1'b1;
          period_stable_n = (period_diff <= TOL_W) && locked_q;
          locked_n        = 1'b1;
          count_n         = '0;
        end else if (count == TIMEOUT) begin
          state_n         = IDLE;
          locked_n        = 1'b0;
          period_stable_n = 1'b0;
          count_n         = '0;
        end else begin
          count_n = count_inc;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign mon.frame         = frame_q;
  assign mon.frame_valid   = frame_valid_q;
  assign mon.digit         = digit_q;
  assign mon.digit_valid   = digit_valid_q;
  assign mon.period        = period_q;
  assign mon.period_valid  = period_valid_q;
  assign mon.period_stable = period_stable_q;
  assign mon.locked        = locked_q;

endmodule

// File: tb/tb_seg7_frame_monitor.sv
// Directed scoreboard bench for seg7_frame_monitor with a short filter,
// a tight tolerance and a short timeout.
module tb_seg7_frame_monitor;

  localparam int PW = 24;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  typedef struct {
    logic [6:0]    frame;
    logic [3:0]    digit;
    logic          digit_valid;
    logic          period_valid;
    logic [PW-1:0] period;
    logic          period_stable;
    logic          locked;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg7_frame_monitor_if #(.PERIOD_WIDTH(PW)) mon_if ();

  seg7_frame_monitor #(
    .STABLE_CYCLES(4),
    .PERIOD_WIDTH (PW),
    .TIMEOUT      (24'd100),
    .TOLERANCE    (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .mon  (mon_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] pattern, input int cycles);
    mon_if.segments_in = pattern;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic pushExpect(input logic [6:0] frame, input logic pv, input logic [PW-1:0] period,
                            input logic ps, input logic lk);
    exp_t e;
    e.frame         = frame;
    e.digit         = 4'h0;
    e.digit_valid   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (glyph_tab[i] == frame) begin
        e.digit       = 4'(i);
        e.digit_valid = 1'b1;
      end
    end
    e.period_valid  = pv;
    e.period        = period;
    e.period_stable = ps;
    e.locked        = lk;
    exp_q.push_back(e);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " frame"},         32'(mon_if.frame), 32'd0);
    checkOutput({tag, " frame_valid"},   32'(mon_if.frame_valid), 32'd0);
    checkOutput({tag, " digit"},         32'(mon_if.digit), 32'd0);
    checkOutput({tag, " digit_valid"},   32'(mon_if.digit_valid), 32'd0);
    checkOutput({tag, " period"},        32'(mon_if.period), 32'd0);
    checkOutput({tag, " period_valid"},  32'(mon_if.period_valid), 32'd0);
    checkOutput({tag, " period_stable"}, 32'(mon_if.period_stable), 32'd0);
    checkOutput({tag, " locked"},        32'(mon_if.locked), 32'd0);
  endtask

  // Every frame_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (mon_if.frame_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected frame_valid", 32'(mon_if.frame_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("sb frame",         32'(mon_if.frame), 32'(mon_e.frame));
        checkOutput("sb digit",         32'(mon_if.digit), 32'(mon_e.digit));
        checkOutput("sb digit_valid",   32'(mon_if.digit_valid), 32'(mon_e.digit_valid));
        checkOutput("sb period_valid",  32'(mon_if.period_valid), 32'(mon_e.period_valid));
        checkOutput("sb period",        32'(mon_if.period), 32'(mon_e.period));
        checkOutput("sb period_stable", 32'(mon_if.period_stable), 32'(mon_e.period_stable));
        checkOutput("sb locked",        32'(mon_if.locked), 32'(mon_e.locked));
      end
    end
  end

  initial begin
    vectors            = 0;
    miscompares        = 0;
    reset              = 1'b1;
    mon_if.segments_in = 7'h00;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    reset = 1'b0;

    $display("[TB] first frame and latency");
    pushExpect(7'h06, 1'b0, 24'd0, 1'b0, 1'b0);
    applyStimulus(7'h06, 6);
    checkOutput("frame_valid before edge 6", 32'(mon_if.frame_valid), 32'd0);
    @(negedge clk);
    checkOutput("frame_valid after edge 6", 32'(mon_if.frame_valid), 32'd1);
    checkOutput("no period on first frame", 32'(mon_if.period_valid), 32'd0);
    checkOutput("unlocked on first frame", 32'(mon_if.locked), 32'd0);
    repeat (13) @(negedge clk);

    $display("[TB] alternating every 20 cycles");
    pushExpect(7'h3F, 1'b1, 24'd20, 1'b0, 1'b1);
    applyStimulus(7'h3F, 20);
    pushExpect(7'h06, 1'b1, 24'd20, 1'b1, 1'b1);
    applyStimulus(7'h06, 20);
    pushExpect(7'h3F, 1'b1, 24'd20, 1'b1, 1'b1);
    applyStimulus(7'h3F, 20);
    checkOutput("period_valid single pulse", 32'(mon_if.period_valid), 32'd0);
    checkOutput("period_stable held", 32'(mon_if.period_stable), 32'd1);
    checkOutput("locked held", 32'(mon_if.locked), 32'd1);

    $display("[TB] glitch rejection");
    applyStimulus(7'h7F, 3);
    applyStimulus(7'h3F, 10);
    checkOutput("short glitch rejected", 32'(mon_if.frame), 32'h3F);
    pushExpect(7'h7F, 1'b1, 24'd33, 1'b0, 1'b1);
    pushExpect(7'h3F, 1'b1, 24'd5, 1'b0, 1'b1);
    applyStimulus(7'h7F, 5);
    applyStimulus(7'h3F, 12);
    checkOutput("frame back to 3F", 32'(mon_if.frame), 32'h3F);

    $display("[TB] illegal glyph");
    pushExpect(7'h01, 1'b1, 24'd12, 1'b0, 1'b1);
    applyStimulus(7'h01, 20);
    checkOutput("illegal digit_valid", 32'(mon_if.digit_valid), 32'd0);
    checkOutput("illegal digit", 32'(mon_if.digit), 32'd0);

    $display("[TB] timeout and relock");
    pushExpect(7'h06, 1'b1, 24'd20, 1'b0, 1'b1);
    applyStimulus(7'h06, 20);
    pushExpect(7'h01, 1'b1, 24'd20, 1'b1, 1'b1);
    applyStimulus(7'h01, 107);
    checkOutput("locked before timeout", 32'(mon_if.locked), 32'd1);
    checkOutput("stable before timeout", 32'(mon_if.period_stable), 32'd1);
    @(negedge clk);
    checkOutput("locked cleared by timeout", 32'(mon_if.locked), 32'd0);
    checkOutput("stable cleared by timeout", 32'(mon_if.period_stable), 32'd0);
    checkOutput("period kept after timeout", 32'(mon_if.period), 32'd20);
    applyStimulus(7'h01, 2);
    pushExpect(7'h3F, 1'b0, 24'd20, 1'b0, 1'b0);
    applyStimulus(7'h3F, 20);
    pushExpect(7'h06, 1'b1, 24'd20, 1'b0, 1'b1);
    applyStimulus(7'h06, 20);

    $display("[TB] reset mid-filter and mid-measurement");
    applyStimulus(7'h3F, 5);
    reset = 1'b1;
    @(negedge clk);
    checkAllZero("mid reset");
    reset = 1'b0;
    pushExpect(7'h3F, 1'b0, 24'd0, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    checkOutput("post-reset frame_valid early", 32'(mon_if.frame_valid), 32'd0);
    @(negedge clk);
    checkOutput("post-reset frame_valid", 32'(mon_if.frame_valid), 32'd1);
    repeat (5) @(negedge clk);
    checkOutput("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
